// File: rtl/reg_native_arb.sv
// Round-robin arbiter funnelling NUM_REQ native register requesters onto one
// downstream port, with one held request per requester and an optional ack timeout.
module reg_native_arb #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              up_req_vld,
    input  logic [NUM_REQ-1:0]              up_wr_en,
    input  logic [NUM_REQ-1:0]              up_rd_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   up_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   up_wr_data,
    output logic [NUM_REQ-1:0]              up_ack_vld,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   up_rd_data,
    output logic [NUM_REQ-1:0]              up_err,
    output logic                            req_vld,
    output logic                            wr_en,
    output logic                            rd_en,
    output logic [ADDR_WIDTH-1:0]           addr,
    output logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            ack_vld,
    input  logic                            err,
    input  logic [DATA_WIDTH-1:0]           rd_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      pending_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        owner_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_REQ-1:0]      hold_wr_q;
    logic [NUM_REQ-1:0]      hold_rd_q;
    logic [ADDR_WIDTH-1:0]   hold_addr_q [NUM_REQ];
    logic [DATA_WIDTH-1:0]   hold_data_q [NUM_REQ];

    logic                    gnt_any;
    logic [IDX_W-1:0]        gnt_idx;
    logic [IDX_W-1:0]        cand;
    logic                    grant;
    logic [NUM_REQ-1:0]      gnt_mask;
    logic [NUM_REQ-1:0]      accept;
    logic                    cpl;
    logic                    cpl_err;
    logic [DATA_WIDTH-1:0]   cpl_data;
    logic [IDX_W-1:0]        cpl_owner;
    logic                    tmo_hit;

    // First pending port at or above rr_ptr, wrapping around
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_any && pending_q[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // A port may post only when its slot is free and it is not the one being serviced
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            accept[i] = up_req_vld[i] & (up_wr_en[i] | up_rd_en[i]) & ~pending_q[i]
                        & ~((state_q == WAIT) && (owner_q == IDX_W'(i)));
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next state plus the combinational downstream request and upstream completion
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        cpl        = 1'b0;
        cpl_err    = 1'b0;
        cpl_data   = '0;
        cpl_owner  = owner_q;
        req_vld    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        addr       = '0;
        wr_data    = '0;
        up_ack_vld = '0;
        up_err     = '0;
        up_rd_data = '0;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    grant     = 1'b1;
                    cpl_owner = gnt_idx;
                    if (ack_vld) begin
                        cpl      = 1'b1;
                        cpl_err  = err;
                        cpl_data = rd_data;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ack_vld) begin
                    cpl      = 1'b1;
                    cpl_err  = err;
                    cpl_data = rd_data;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    cpl     = 1'b1;
                    cpl_err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            req_vld = 1'b1;
            wr_en   = hold_wr_q[gnt_idx];
            rd_en   = hold_rd_q[gnt_idx];
            addr    = hold_addr_q[gnt_idx];
            wr_data = hold_data_q[gnt_idx];
        end

        if (cpl) begin
            up_ack_vld[cpl_owner] = 1'b1;
            up_err[cpl_owner]     = cpl_err;
            up_rd_data[32'(cpl_owner)*DATA_WIDTH +: DATA_WIDTH] = cpl_data;
        end
    end

    assign gnt_mask = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending slots, held payloads, round-robin pointer, owner and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            hold_wr_q <= '0;
            hold_rd_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                hold_addr_q[i] <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~gnt_mask) | accept;
            if (grant) begin
                owner_q  <= gnt_idx;
                rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    hold_wr_q[i]   <= up_wr_en[i];
                    hold_rd_q[i]   <= up_rd_en[i];
                    hold_addr_q[i] <= up_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    hold_data_q[i] <= up_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_native_arb.sv
// Bench for reg_native_arb: directed vector table, hand-written corner sequences and
// random traffic, all shadowed every cycle by a transaction-level reference model.
module tb_reg_native_arb;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [N-1:0]        up_req_vld = '0;
    logic [N-1:0]        up_wr_en = '0;
    logic [N-1:0]        up_rd_en = '0;
    logic [N*AW-1:0]     up_addr = '0;
    logic [N*DW-1:0]     up_wr_data = '0;
    logic [N-1:0]        up_ack_vld;
    logic [N*DW-1:0]     up_rd_data;
    logic [N-1:0]        up_err;
    logic                req_vld, wr_en, rd_en;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       wr_data;
    logic                ack_vld = 1'b0;
    logic                err = 1'b0;
    logic [DW-1:0]       rd_data = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_native_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req_vld(up_req_vld), .up_wr_en(up_wr_en), .up_rd_en(up_rd_en),
        .up_addr(up_addr), .up_wr_data(up_wr_data),
        .up_ack_vld(up_ack_vld), .up_rd_data(up_rd_data), .up_err(up_err),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .err(err), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: requests, one outstanding transfer, age since grant
    bit            m_pend [N];
    bit            m_wr   [N];
    bit            m_rd   [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_wdat [N];
    int            m_rr;
    bit            m_busy;
    int            m_own;
    int            m_age;

    always @(negedge clk) begin : model_chk
        bit            g, cpl, cerr;
        int            w, c, co;
        logic [DW-1:0] cdat;
        logic [98:0]   e_req;
        logic [N-1:0]  e_ack, e_err;
        logic [N*DW-1:0] e_rdd;
        bit            acc [N];

        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_wr[i] = 0; m_rd[i] = 0; m_addr[i] = '0; m_wdat[i] = '0;
            end
            m_rr = 0; m_busy = 0; m_own = 0; m_age = 0;
        end

        g = 0; w = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (!g && m_pend[c]) begin g = 1; w = c; end
            end
        end
        e_req = g ? {1'b1, m_wr[w], m_rd[w], m_addr[w], m_wdat[w]} : '0;

        cpl = 0; co = 0; cerr = 0; cdat = '0;
        if (g && ack_vld) begin
            cpl = 1; co = w; cerr = err; cdat = rd_data;
        end else if (m_busy && ack_vld) begin
            cpl = 1; co = m_own; cerr = err; cdat = rd_data;
        end else if (m_busy && m_age == TO) begin
            cpl = 1; co = m_own; cerr = 1;
        end
        e_ack = '0; e_err = '0; e_rdd = '0;
        if (cpl) begin
            e_ack[co] = 1'b1;
            e_err[co] = cerr;
            e_rdd[co*DW +: DW] = cdat;
        end

        chk("model_req", 256'({req_vld, wr_en, rd_en, addr, wr_data}), 256'(e_req));
        chk("model_cpl", 256'({up_ack_vld, up_err, up_rd_data}), 256'({e_ack, e_err, e_rdd}));

        if (rst_n) begin
            for (int i = 0; i < N; i++)
                acc[i] = up_req_vld[i] && (up_wr_en[i] || up_rd_en[i]) && !m_pend[i]
                         && !(m_busy && m_own == i);
            if (m_busy) begin
                if (cpl) m_busy = 0;
                else     m_age++;
            end
            if (g) begin
                m_pend[w] = 0;
                m_rr = (w + 1) % N;
                if (!ack_vld) begin m_busy = 1; m_own = w; m_age = 1; end
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    m_pend[i] = 1;
                    m_wr[i]   = up_wr_en[i];
                    m_rd[i]   = up_rd_en[i];
                    m_addr[i] = up_addr[i*AW +: AW];
                    m_wdat[i] = up_wr_data[i*DW +: DW];
                end
            end
        end
    end

    // ---------------- directed single-transfer vectors
    typedef struct {
        int          port;
        bit          wr;
        bit          rd;
        logic [63:0] a;
        logic [31:0] wd;
        int          ack_dly;     // cycles after grant that ack_vld is driven; 99 = never
        bit          ack_err;
        logic [31:0] rdat;
        int          exp_off;     // expected completion cycle relative to grant
        bit          exp_err;
        logic [31:0] exp_rdat;
    } vec_t;

    task automatic do_reset();
        rst_n = 1'b0;
        up_req_vld = '0; up_wr_en = '0; up_rd_en = '0; up_addr = '0; up_wr_data = '0;
        ack_vld = 1'b0; err = 1'b0; rd_data = '0;
        #1;
        chk("reset_outputs",
            256'({req_vld, wr_en, rd_en, addr, wr_data, up_ack_vld, up_err, up_rd_data}), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_row(input vec_t v);
        int off;
        bit seen;
        up_req_vld = '0;
        up_req_vld[v.port] = 1'b1;
        up_wr_en[v.port] = v.wr;
        up_rd_en[v.port] = v.rd;
        up_addr[v.port*AW +: AW] = v.a;
        up_wr_data[v.port*DW +: DW] = v.wd;
        @(posedge clk); #1;
        up_req_vld = '0;
        seen = 0; off = -1;
        for (int c = 0; c < 20 && !seen; c++) begin
            ack_vld = (c == v.ack_dly);
            rd_data = v.rdat;
            err     = v.ack_err;
            @(negedge clk);
            if (c == 0)
                chk("row_req", 256'({req_vld, wr_en, rd_en, addr, wr_data}),
                    256'({1'b1, v.wr, v.rd, v.a, v.wd}));
            if (up_ack_vld != '0) begin
                seen = 1; off = c;
                chk("row_cpl", 256'({up_ack_vld, up_err, up_rd_data}),
                    256'({4'(1) << v.port, 4'(v.exp_err) << v.port,
                          128'(v.exp_rdat) << (v.port * DW)}));
            end
            @(posedge clk); #1;
        end
        ack_vld = 1'b0;
        chk("row_cpl_cycle", 256'(off), 256'(v.exp_off));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- hand-written sequences
    task automatic seq_rr();
        int order[$];
        int exp_o[5] = '{0, 1, 3, 0, 3};
        int ack_at = -1;
        int new_at = -1;
        int got;
        do_reset();
        for (int i = 0; i < N; i++) up_addr[i*AW +: AW] = 64'(i);
        up_rd_en = 4'hF;
        for (int cyc = 0; cyc < 80; cyc++) begin
            up_req_vld = (cyc == 0) ? 4'b1011 : (cyc == new_at) ? 4'b1001 : 4'b0000;
            ack_vld = (cyc == ack_at);
            rd_data = 32'(cyc);
            err = 1'b0;
            @(negedge clk);
            if (req_vld) begin
                order.push_back(int'(addr[3:0]));
                ack_at = cyc + 3;
            end
            if (ack_vld && order.size() == 3 && new_at < 0) new_at = cyc + 1;
            @(posedge clk); #1;
        end
        up_req_vld = '0; ack_vld = 1'b0;
        chk("rr_count", 256'(order.size()), 256'(5));
        for (int k = 0; k < 5; k++) begin
            got = (k < order.size()) ? order[k] : -1;
            chk($sformatf("rr_order[%0d]", k), 256'(got), 256'(exp_o[k]));
        end
    endtask

    task automatic seq_guard();
        int nreq = 0;
        int p1 = 0;
        logic [63:0] last_a = '0;
        do_reset();
        up_addr[0 +: AW] = 64'hA0;
        up_rd_en = 4'b0001;
        up_wr_en = 4'b0000;
        for (int cyc = 0; cyc < 20; cyc++) begin
            up_req_vld = (cyc == 0) ? 4'b0011 : (cyc == 1 || cyc == 2) ? 4'b0001 : 4'b0000;
            if (cyc == 1) up_addr[0 +: AW] = 64'hB0;
            ack_vld = (cyc == 4);
            @(negedge clk);
            if (req_vld) begin nreq++; last_a = addr; end
            if (up_ack_vld[1]) p1++;
            @(posedge clk); #1;
        end
        up_req_vld = '0; ack_vld = 1'b0;
        chk("guard_req_count", 256'(nreq), 256'(1));
        chk("guard_held_addr", 256'(last_a), 256'(64'hA0));
        chk("guard_port1_acks", 256'(p1), 256'(0));
    endtask

    task automatic seq_reset_wait();
        int nreq = 0;
        int nack = 0;
        do_reset();
        up_rd_en = 4'b0111;
        up_addr[0 +: AW] = 64'h300;
        up_addr[2*AW +: AW] = 64'h320;
        up_req_vld = 4'b0101;
        @(posedge clk); #1;
        up_req_vld = '0;
        @(posedge clk); #1;     // grant cycle for port 0
        @(posedge clk); #1;     // first WAIT cycle, port 2 still pending
        rst_n = 1'b0;
        ack_vld = 1'b1;
        rd_data = 32'hFFFF_FFFF;
        #1;
        chk("rst_mid_wait_outputs",
            256'({req_vld, wr_en, rd_en, addr, wr_data, up_ack_vld, up_err, up_rd_data}), 256'(0));
        @(posedge clk); #1;
        ack_vld = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            ack_vld = (c == 1);
            @(negedge clk);
            if (req_vld) nreq++;
            if (up_ack_vld != '0) nack++;
            @(posedge clk); #1;
        end
        ack_vld = 1'b0;
        chk("post_rst_req", 256'(nreq), 256'(0));
        chk("post_rst_ack", 256'(nack), 256'(0));
        up_addr[AW +: AW] = 64'h310;
        up_req_vld = 4'b0010;
        @(posedge clk); #1;
        up_req_vld = '0;
        @(negedge clk);
        chk("post_rst_new_req", 256'({req_vld, rd_en, addr}), 256'({1'b1, 1'b1, 64'h310}));
        ack_vld = 1'b0;
        @(posedge clk); #1;
        ack_vld = 1'b1;
        @(posedge clk); #1;
        ack_vld = 1'b0;
    endtask

    task automatic seq_late_ack();
        int npulse = 0;
        int first = -1;
        do_reset();
        up_wr_en = 4'b0010;
        up_addr[AW +: AW] = 64'h2000;
        up_wr_data[DW +: DW] = 32'h5A5A;
        up_req_vld = 4'b0010;
        @(posedge clk); #1;
        up_req_vld = '0;
        for (int c = 0; c < 16; c++) begin
            ack_vld = (c == 10);
            rd_data = 32'h77;
            err = 1'b0;
            @(negedge clk);
            if (up_ack_vld != '0) begin
                npulse++;
                if (first < 0) begin
                    first = c;
                    chk("tmo_cpl", 256'({up_ack_vld, up_err, up_rd_data}),
                        256'({4'b0010, 4'b0010, 128'h0}));
                end
            end
            @(posedge clk); #1;
        end
        ack_vld = 1'b0;
        chk("tmo_cycle", 256'(first), 256'(8));
        chk("late_ack_dropped", 256'(npulse), 256'(1));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[6];
        tbl[0] = '{2, 1'b0, 1'b1, 64'h40,   32'h0,        0, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{0, 1'b1, 1'b0, 64'h1000, 32'h12345678, 3, 1'b1, 32'h0000AAAA, 3, 1'b1, 32'h0000AAAA};
        tbl[2] = '{3, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 7, 1'b0, 32'h13579BDF, 7, 1'b0, 32'h13579BDF};
        tbl[3] = '{1, 1'b1, 1'b0, 64'h88,   32'hCAFEF00D, 99, 1'b0, 32'h11111111, 8, 1'b1, 32'h0};
        tbl[4] = '{1, 1'b0, 1'b1, 64'h90,   32'h0,        8, 1'b0, 32'h2468ACE0, 8, 1'b0, 32'h2468ACE0};
        tbl[5] = '{0, 1'b1, 1'b1, 64'h7F0,  32'hA5A5A5A5, 1, 1'b0, 32'h0BADC0DE, 1, 1'b0, 32'h0BADC0DE};

        #2;
        do_reset();
        for (int r = 0; r < 6; r++) run_row(tbl[r]);

        seq_rr();
        seq_guard();
        seq_late_ack();
        seq_reset_wait();

        // random traffic, checked cycle by cycle by the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < N; i++) begin
                up_req_vld[i] = ($urandom_range(0, 3) == 0);
                up_wr_en[i]   = 1'($urandom);
                up_rd_en[i]   = 1'($urandom);
                up_addr[i*AW +: AW]    = {$urandom, $urandom};
                up_wr_data[i*DW +: DW] = $urandom;
            end
            ack_vld = ($urandom_range(0, 5) == 0);
            err     = 1'($urandom);
            rd_data = $urandom;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        up_req_vld = '0;
        ack_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_native_arb.md
REG_NATIVE_ARB -- requirements
Module: reg_native_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, address width of every port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of every port.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of upstream requesters; legal range 2..16.
REQ-004 SHALL have parameter TIMEOUT, default 256, wait cycles before error completion; 0 disables timeout.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port up_req_vld, input, NUM_REQ, per-requester single-cycle request pulse.
REQ-008 SHALL have ports up_wr_en and up_rd_en, input, NUM_REQ each, per-requester access type.
REQ-009 SHALL have ports up_addr and up_wr_data, input, NUM_REQ*ADDR_WIDTH and NUM_REQ*DATA_WIDTH, flattened, port i at slice i.
REQ-010 SHALL have port up_ack_vld, output, NUM_REQ, per-requester single-cycle completion pulse.
REQ-011 SHALL have ports up_rd_data (output, NUM_REQ*DATA_WIDTH) and up_err (output, NUM_REQ), completion read data and error.
REQ-012 SHALL have ports req_vld, wr_en, rd_en (output, 1 each), addr (output, ADDR_WIDTH), wr_data (output, DATA_WIDTH), downstream request.
REQ-013 SHALL have ports ack_vld, err (input, 1 each), rd_data (input, DATA_WIDTH), downstream completion.

Function
REQ-014 SHALL accept an upstream request only when up_req_vld[i] & (up_wr_en[i] | up_rd_en[i]); otherwise no pending entry is created.
REQ-015 SHALL latch an accepted request (wr_en, rd_en, addr, wr_data) into a one-entry per-port holding register and set pending[i] at the next edge.
REQ-016 SHALL ignore a new up_req_vld[i] while pending[i] is set or port i owns the outstanding transfer; the held request is unchanged.
REQ-017 SHALL implement states IDLE and WAIT; reset state IDLE.
REQ-018 SHALL, in IDLE with any pending bit set, grant the first pending port searching upward from rr_ptr with wrap-around, in that same cycle.
REQ-019 SHALL, on grant, drive req_vld=1 for exactly one cycle with the winner's held wr_en/rd_en/addr/wr_data, clear pending[winner], and set rr_ptr to (winner+1) mod NUM_REQ.
REQ-020 SHALL drive wr_en, rd_en, addr, wr_data to zero whenever req_vld is 0.
REQ-021 SHALL, if ack_vld=1 in the grant cycle, complete immediately and remain in IDLE; otherwise go to WAIT.
REQ-022 SHALL, in WAIT, keep req_vld=0, increment a wait counter from 0 each cycle, and return to IDLE on ack_vld=1.
REQ-023 SHALL on completion pulse up_ack_vld[owner]=1 for one cycle, combinationally in the cycle ack_vld is seen, with up_rd_data[owner]=rd_data and up_err[owner]=err.
REQ-024 SHALL, with TIMEOUT>0, when the wait counter reaches TIMEOUT-1 without ack_vld, pulse up_ack_vld[owner] with up_err[owner]=1 and up_rd_data[owner]=0, and return to IDLE.
REQ-025 SHALL drop any ack_vld seen in IDLE with no grant in that cycle (late ack after timeout); no upstream pulse.
REQ-026 SHALL drive up_ack_vld, up_rd_data, up_err to zero for every non-owner port and for all ports when no completion occurs.
REQ-027 SHALL give latency of 1 cycle from accepted up_req_vld to req_vld when the arbiter is IDLE with no other pending port; the next grant is no earlier than the cycle after a completion.
REQ-028 SHALL accept a new request on port j in the same cycle another port is granted or completed; it is arbitrated from the next cycle.

Reset
REQ-029 SHALL on rst_n low asynchronously clear state to IDLE, pending to 0, rr_ptr to 0, wait counter to 0 and held registers to 0; all outputs read 0.
REQ-030 SHALL on reset mid-transfer abandon the outstanding request without any upstream completion; a subsequent ack_vld is dropped per REQ-025.

Verification
REQ-031 Single read: port 2 read addr 0x40, ack_vld same cycle as req_vld, rd_data 0xDEADBEEF -> req_vld 1 cycle after request, up_ack_vld[2]=1 same cycle, up_rd_data slice 2 = 0xDEADBEEF, up_err[2]=0.
REQ-032 Round-robin: ports 0,1,3 request in same cycle, rr_ptr=0, each acked after 2 wait cycles -> grant order 0,1,3, then new requests on 0 and 3 grant 0 then 3 (rr_ptr=0 after 3).
REQ-033 Timeout: TIMEOUT=8, port 1 write, no ack_vld -> up_ack_vld[1] exactly 8 cycles after grant with up_err[1]=1, rd_data 0; ack_vld 2 cycles later produces no upstream pulse.
REQ-034 Protocol guard: port 0 pulses up_req_vld twice while pending, and port 1 pulses with wr_en=rd_en=0 -> only the first port 0 request issued; no transfer for port 1.
REQ-035 Reset mid-WAIT: assert rst_n low during WAIT with port 2 pending -> all outputs 0 immediately, after release no req_vld and no up_ack_vld until a new request.
